// File: rtl/traffic_ctrl_nway.sv
// N-road traffic-light controller: min/max green, timed yellow and all-red, round-robin hand-off.
// Optional emergency preemption (emerg, emerg_road ports) enabled by TRAFFIC_EMERG_PREEMPT_EN.
module traffic_ctrl_nway #(
    parameter int unsigned NUM_ROADS    = 4,
    parameter int unsigned MIN_GREEN    = 4,
    parameter int unsigned MAX_GREEN    = 16,
    parameter int unsigned YELLOW_TIME  = 2,
    parameter int unsigned ALL_RED_TIME = 1,
    localparam int unsigned RW = ($clog2(NUM_ROADS) < 1) ? 1 : $clog2(NUM_ROADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_ROADS-1:0]     car,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    input  logic                     emerg,
    input  logic [RW-1:0]            emerg_road,
`endif
    output logic [3*NUM_ROADS-1:0]   light,
    output logic [RW-1:0]            active_road,
    output logic [1:0]               phase
);

    localparam int unsigned TMAX_A = (MAX_GREEN > YELLOW_TIME) ? MAX_GREEN : YELLOW_TIME;
    localparam int unsigned TMAX   = (TMAX_A > ALL_RED_TIME) ? TMAX_A : ALL_RED_TIME;
    localparam int unsigned CW     = $clog2(TMAX) + 1;

    localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_TIME - 1);
    localparam logic [CW-1:0] AR_LAST  = CW'((ALL_RED_TIME == 0) ? 0 : ALL_RED_TIME - 1);

    localparam logic [3*NUM_ROADS-1:0] LIGHT_RST = {{(NUM_ROADS-1){3'b100}}, 3'b001};

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } state_t;

    state_t                   state, state_nx;
    logic [CW-1:0]            cnt, cnt_nx;
    logic [RW-1:0]            active_nx;
    logic [RW-1:0]            next_road, next_nx;
    logic [3*NUM_ROADS-1:0]   light_nx;

    logic [NUM_ROADS-1:0]     others_c;
    logic                     other_req_c;
    logic                     own_c;
    logic [RW-1:0]            rr_pick_c;
    logic                     rr_found_c;
    logic                     go_c;
    logic [RW-1:0]            tgt_c;

    // Request picture relative to the current green owner
    always_comb begin
        others_c              = car;
        others_c[active_road] = 1'b0;
        other_req_c           = |others_c;
        own_c                 = car[active_road];
    end

    // First waiting road after the current one, wrapping around
    always_comb begin
        rr_pick_c  = active_road;
        rr_found_c = 1'b0;
        for (int k = 1; k < int'(NUM_ROADS); k++) begin
            if (!rr_found_c && car[RW'((int'(active_road) + k) % int'(NUM_ROADS))]) begin
                rr_pick_c  = RW'((int'(active_road) + k) % int'(NUM_ROADS));
                rr_found_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        active_nx = active_road;
        next_nx   = next_road;
        go_c      = 1'b0;
        tgt_c     = rr_pick_c;
        light_nx  = {NUM_ROADS{3'b100}};

        case (state)
            GREEN: begin
                go_c = other_req_c && ((cnt >= MIN_LAST && !own_c) || cnt >= MAX_LAST);
`ifdef TRAFFIC_EMERG_PREEMPT_EN
                if (emerg) begin
                    go_c  = (emerg_road != active_road);
                    tgt_c = emerg_road;
                end
`endif
                if (go_c) begin
                    state_nx = YELLOW;
                    cnt_nx   = '0;
                    next_nx  = tgt_c;
                end else if (cnt != MAX_LAST) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            YELLOW: begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
                if (emerg) next_nx = emerg_road;
`endif
                if (cnt == YEL_LAST) begin
                    cnt_nx = '0;
                    if (ALL_RED_TIME == 0) begin
                        state_nx  = GREEN;
                        active_nx = next_nx;
                    end else begin
                        state_nx = ALL_RED;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ALL_RED: begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
                if (emerg) next_nx = emerg_road;
`endif
                if (cnt == AR_LAST) begin
                    state_nx  = GREEN;
                    cnt_nx    = '0;
                    active_nx = next_nx;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx  = GREEN;
                cnt_nx    = '0;
                active_nx = '0;
                next_nx   = '0;
            end
        endcase

        // Lights follow the upcoming state so the registered copy matches it
        for (int i = 0; i < int'(NUM_ROADS); i++) begin
            if (RW'(i) == active_nx && state_nx == GREEN)
                light_nx[3*i +: 3] = 3'b001;
            else if (RW'(i) == active_nx && state_nx == YELLOW)
                light_nx[3*i +: 3] = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= GREEN;
            cnt         <= '0;
            active_road <= '0;
            next_road   <= '0;
            light       <= LIGHT_RST;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            active_road <= active_nx;
            next_road   <= next_nx;
            light       <= light_nx;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Randomized + directed bench for traffic_ctrl_nway against a behavioural timing model.
// Build with TRAFFIC_EMERG_PREEMPT_EN to also exercise emergency preemption.
module tb_traffic_ctrl_nway;

    localparam int N   = 4;
    localparam int MIN = 4;
    localparam int MAX = 16;
    localparam int YT  = 2;
    localparam int ART = 1;

    logic            clk;
    logic            rst;
    logic [N-1:0]    car;
    logic            emerg;
    logic [1:0]      emerg_road;
    logic [3*N-1:0]  light;
    logic [1:0]      active_road;
    logic [1:0]      phase;

    int total = 0;
    int bad   = 0;

    // Reference model: phase, owner, elapsed cycles in phase, latched target
    int m_ph, m_act, m_el, m_tgt;

    traffic_ctrl_nway dut (
        .clk         (clk),
        .rst         (rst),
        .car         (car),
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        .emerg       (emerg),
        .emerg_road  (emerg_road),
`endif
        .light       (light),
        .active_road (active_road),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3*N-1:0] model_light(input int ph, input int act);
        logic [3*N-1:0] l;
        for (int i = 0; i < N; i++) begin
            if (i == act && ph == 0)      l[3*i +: 3] = 3'b001;
            else if (i == act && ph == 1) l[3*i +: 3] = 3'b010;
            else                          l[3*i +: 3] = 3'b100;
        end
        return l;
    endfunction

    task automatic model_step();
        bit others, own, go;
        int pick;
        bit emg;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        emg = emerg;
`else
        emg = 1'b0;
`endif
        if (rst) begin
            m_ph = 0; m_act = 0; m_el = 0; m_tgt = 0;
            return;
        end
        case (m_ph)
            0: begin
                others = 0;
                for (int j = 0; j < N; j++) if (j != m_act && car[j]) others = 1;
                own  = car[m_act];
                go   = others && ((m_el >= MIN - 1 && !own) || m_el >= MAX - 1);
                pick = -1;
                for (int k = 1; k < N; k++)
                    if (pick < 0 && car[(m_act + k) % N]) pick = (m_act + k) % N;
                if (emg) begin
                    go   = (int'(emerg_road) != m_act);
                    pick = int'(emerg_road);
                end
                if (go) begin
                    m_ph = 1; m_el = 0; m_tgt = pick;
                end else begin
                    m_el++;
                end
            end
            1: begin
                if (emg) m_tgt = int'(emerg_road);
                m_el++;
                if (m_el == YT) begin
                    m_el = 0;
                    if (ART == 0) begin m_ph = 0; m_act = m_tgt; end
                    else m_ph = 2;
                end
            end
            default: begin
                if (emg) m_tgt = int'(emerg_road);
                m_el++;
                if (m_el == ART) begin
                    m_el = 0; m_ph = 0; m_act = m_tgt;
                end
            end
        endcase
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("phase",  32'(phase),       32'(m_ph));
        check("active", 32'(active_road), 32'(m_act));
        check("light",  32'(light),       32'(model_light(m_ph, m_act)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; car = '0; emerg = 1'b0; emerg_road = '0;
        m_ph = 0; m_act = 0; m_el = 0; m_tgt = 0;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_light", 32'(light), 32'(12'b100_100_100_001));

        // Single waiter: min green, yellow, all-red, then road 2
        car = 4'b0100;
        repeat (7) cyc();
        check("s1_active", 32'(active_road), 32'd2);
        check("s1_light",  32'(light),       32'(12'b100_001_100_100));

        // Contending roads: max-green preemption both ways
        do_reset();
        car = 4'b0011;
        repeat (19) cyc();
        check("s2_road1", 32'(active_road), 32'd1);
        repeat (19) cyc();
        check("s2_road0", 32'(active_road), 32'd0);

        // Idle: green holds on road 0
        do_reset();
        car = 4'b0000;
        repeat (100) cyc();
        check("s3_phase", 32'(phase), 32'd0);
        check("s3_light", 32'(light), 32'(12'b100_100_100_001));

        // Wrap-around from road 3, target fixed once latched
        do_reset();
        car = 4'b1000;
        repeat (7) cyc();
        check("s4_road3", 32'(active_road), 32'd3);
        car = 4'b0101;
        repeat (4) cyc();
        check("s4_yellow", 32'(phase), 32'd1);
        car = 4'b0100;
        repeat (3) cyc();
        check("s4_road0", 32'(active_road), 32'd0);
        check("s4_green", 32'(phase), 32'd0);

        // Reset in the second yellow cycle
        do_reset();
        car = 4'b0100;
        repeat (5) cyc();
        check("s5_yel2", 32'(phase), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("s5_phase", 32'(phase), 32'd0);
        check("s5_light", 32'(light), 32'(12'b100_100_100_001));

`ifdef TRAFFIC_EMERG_PREEMPT_EN
        // Emergency request jumps the queue
        do_reset();
        car = 4'b0010;
        cyc();
        emerg = 1'b1; emerg_road = 2'd3;
        cyc();
        check("e_yellow", 32'(phase), 32'd1);
        emerg = 1'b0;
        repeat (3) cyc();
        check("e_road3", 32'(active_road), 32'd3);
        check("e_green", 32'(phase), 32'd0);
`endif

        // Random traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) car = 4'($urandom);
            rst = ($urandom_range(0, 249) == 0);
`ifdef TRAFFIC_EMERG_PREEMPT_EN
            emerg      = ($urandom_range(0, 39) == 0);
            emerg_road = 2'($urandom);
`endif
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
